// File: rtl/set_tr_dequeue_cmd.sv
// Set TR Dequeue Pointer command handler: decodes the TRB, validates it against the slot
// context, writes the new dequeue pointer into the endpoint context and pulses the update bus.
module set_tr_dequeue_cmd #(
    parameter logic [5:0]            TRB_TYPE_SET_TR_DEQ = 6'd16,
    parameter logic                  STREAMS_SUPPORTED   = 1'b0,
    parameter int                    WR_STATE_W          = 3,
    parameter logic [WR_STATE_W-1:0] WR_DATA_INIT        = 3'd1,
    parameter logic [WR_STATE_W-1:0] WR_COMPLETE         = 3'd3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_has_request,
    input  logic [127:0]          cmd_trb,
    output logic                  cmd_done,
    output logic [7:0]            cmd_completion_code,
    output logic [7:0]            cmd_slot_id,
    // slot context lookup
    input  logic [7:0][63:0]      slot_p_ctx_i,
    input  logic [7:0]            slot_enabled_i,
    // host memory write port
    output logic [63:0]           wr_address_o,
    output logic [31:0]           wr_data_length_o,
    output logic                  wr_has_data_o,
    output logic [127:0]          wr_din_o,
    output logic                  wr_en_o,
    output logic                  wr_done_o,
    input  logic [WR_STATE_W-1:0] wr_state_i,
    output logic [73:0]           set_ep_tr_ptr_out,
    output logic [2:0]            state_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DECODE   = 3'd1,
        S_CHECK    = 3'd2,
        S_WR_START = 3'd3,
        S_WR_DATA  = 3'd4,
        S_WR_WAIT  = 3'd5,
        S_UPDATE   = 3'd6,
        S_COMPLETE = 3'd7
    } state_t;

    localparam logic [7:0] CC_SUCCESS   = 8'd1;
    localparam logic [7:0] CC_TRB_ERR   = 8'd5;
    localparam logic [7:0] CC_SLOT_NEN  = 8'd11;
    localparam logic [7:0] CC_PARAM_ERR = 8'd17;

    state_t      state_q, state_d;
    logic [59:0] ptr_q;
    logic        dcs_q;
    logic [15:0] stream_q;
    logic [5:0]  type_q;
    logic [4:0]  ep_q;
    logic [7:0]  slot_q;
    logic [2:0]  slot_idx_q;
    logic [63:0] addr_q;
    logic [7:0]  code_q;

    logic        chk_err;
    logic [7:0]  chk_code;

    // TRB bits that carry nothing this command uses
    logic unused_trb;
    assign unused_trb = ^{cmd_trb[79:64], cmd_trb[105:96], cmd_trb[119:117], cmd_trb[3:1]};

    // Checks are ordered: the first failing rule decides the completion code.
    always_comb begin
        chk_err  = 1'b1;
        chk_code = CC_TRB_ERR;
        if (type_q != TRB_TYPE_SET_TR_DEQ) begin
            chk_code = CC_TRB_ERR;
        end else if (slot_q == 8'd0 || slot_q > 8'd8 || !slot_enabled_i[slot_idx_q]) begin
            chk_code = CC_SLOT_NEN;
        end else if (ep_q < 5'd2) begin
            chk_code = CC_TRB_ERR;
        end else if (stream_q != 16'd0 && !STREAMS_SUPPORTED) begin
            chk_code = CC_TRB_ERR;
        end else if (ptr_q == 60'd0) begin
            chk_code = CC_PARAM_ERR;
        end else begin
            chk_err  = 1'b0;
            chk_code = 8'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (cmd_has_request) state_d = S_DECODE;
            S_DECODE:   state_d = S_CHECK;
            S_CHECK:    state_d = chk_err ? S_COMPLETE : S_WR_START;
            S_WR_START: if (wr_state_i == WR_DATA_INIT) state_d = S_WR_DATA;
            S_WR_DATA:  state_d = S_WR_WAIT;
            S_WR_WAIT:  if (wr_state_i == WR_COMPLETE) state_d = S_UPDATE;
            S_UPDATE:   state_d = S_COMPLETE;
            S_COMPLETE: if (!cmd_has_request) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command fields are captured once in DECODE; later TRB changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            dcs_q      <= 1'b0;
            stream_q   <= '0;
            type_q     <= '0;
            ep_q       <= '0;
            slot_q     <= '0;
            slot_idx_q <= '0;
            addr_q     <= '0;
            code_q     <= '0;
        end else begin
            case (state_q)
                S_DECODE: begin
                    ptr_q      <= cmd_trb[63:4];
                    dcs_q      <= cmd_trb[0];
                    stream_q   <= cmd_trb[95:80];
                    type_q     <= cmd_trb[111:106];
                    ep_q       <= cmd_trb[116:112];
                    slot_q     <= cmd_trb[127:120];
                    slot_idx_q <= cmd_trb[122:120] - 3'd1;
                    code_q     <= '0;
                end
                S_CHECK: begin
                    // Endpoint context is 0x20 bytes; the dequeue pointer sits 8 bytes in.
                    addr_q <= slot_p_ctx_i[slot_idx_q] + {54'h0, ep_q, 5'h0} + 64'h8;
                    if (chk_err) code_q <= chk_code;
                end
                S_UPDATE: code_q <= CC_SUCCESS;
                default: ;
            endcase
        end
    end

    always_comb begin
        wr_address_o      = '0;
        wr_data_length_o  = '0;
        wr_has_data_o     = 1'b0;
        wr_din_o          = '0;
        wr_en_o           = 1'b0;
        wr_done_o         = 1'b0;
        set_ep_tr_ptr_out = '0;
        case (state_q)
            S_WR_START: begin
                wr_address_o     = addr_q;
                wr_data_length_o = 32'h8;
                wr_has_data_o    = 1'b1;
            end
            S_WR_DATA: begin
                wr_address_o     = addr_q;
                wr_data_length_o = 32'h8;
                wr_has_data_o    = 1'b1;
                wr_en_o          = 1'b1;
                wr_din_o         = {64'h0, ptr_q, 3'b000, dcs_q};
            end
            S_WR_WAIT: begin
                wr_address_o     = addr_q;
                wr_data_length_o = 32'h8;
                wr_has_data_o    = 1'b1;
                wr_done_o        = 1'b1;
            end
            S_UPDATE: set_ep_tr_ptr_out = {dcs_q, ptr_q, 4'b0, ep_q, slot_q[2:0], 1'b1};
            default: ;
        endcase
    end

    assign cmd_done            = (state_q == S_COMPLETE);
    assign cmd_completion_code = code_q;
    assign cmd_slot_id         = slot_q;
    assign state_o             = state_q;

endmodule
